// File: rtl/arith_unit_seq.sv
// arith_unit_seq: multi-cycle sliced adder with B-operand select, accumulator
// and valid/ready handshakes on both sides.
module arith_unit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  input  logic             C_in,
  input  logic             ACC_SEL,
  input  logic             ACC_CLR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             C_out,
  output logic             V,
  output logic             Z,
  output logic             N
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = NS > 1 ? $clog2(NS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_d, r_acc;
  logic             r_c, r_cout, r_v, r_z, r_n;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] w_bsel, w_d_next;
  logic [SLICE-1:0] w_as, w_bs;
  logic [SLICE:0]   w_sum;
  logic             w_last;
  assign w_bsel = S == 2'b00 ? B : S == 2'b01 ? ~B : S == 2'b10 ? '0 : '1;
  assign w_as   = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_bs   = r_b[int'(r_idx)*SLICE +: SLICE];
  assign w_sum  = {1'b0, w_as} + {1'b0, w_bs} + {{SLICE{1'b0}}, r_c};
  assign w_last = r_idx == IW'(NS - 1);
  always_comb begin
    w_d_next = r_d;
    w_d_next[int'(r_idx)*SLICE +: SLICE] = w_sum[SLICE-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= ACC_SEL ? r_acc : A;
            r_b     <= w_bsel;
            r_c     <= C_in;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end else if (ACC_CLR) begin
            r_acc <= '0;
          end
        end
        ST_RUN: begin
          r_d   <= w_d_next;
          r_c   <= w_sum[SLICE];
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_sum[SLICE];
            // carry into the MSB recovered from the MSB's sum and operand bits
            r_v     <= w_sum[SLICE] ^ w_as[SLICE-1] ^ w_bs[SLICE-1] ^ w_sum[SLICE-1];
            r_z     <= ~|w_d_next;
            r_n     <= w_d_next[WIDTH-1];
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc   <= r_d;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign in_ready  = rst_n && r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign D         = r_d;
  assign C_out     = r_cout;
  assign V         = r_v;
  assign Z         = r_z;
  assign N         = r_n;
endmodule

// File: tb/tb_arith_unit_seq.sv
// tb_arith_unit_seq: scoreboard bench for arith_unit_seq (WIDTH=16, SLICE=4).
module tb_arith_unit_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [15:0] A = 0, B = 0, D;
  logic [1:0]  S = 0;
  logic        C_in = 0, ACC_SEL = 0, ACC_CLR = 0, out_valid, out_ready = 0;
  logic        C_out, V, Z, N;
  typedef struct packed {logic [15:0] d; logic c, v, z, n;} exp_t;
  exp_t        q[$];
  int          n_checks = 0, n_fail = 0;
  logic [15:0] model_acc = 0, last_d = 0;

  arith_unit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .S(S), .C_in(C_in), .ACC_SEL(ACC_SEL), .ACC_CLR(ACC_CLR),
    .out_valid(out_valid), .out_ready(out_ready), .D(D), .C_out(C_out),
    .V(V), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, b, input logic [1:0] s, input logic cin, accsel);
    logic [15:0] aop, bs;
    logic [16:0] sum;
    exp_t e;
    aop = accsel ? model_acc : a;
    bs = s == 2'd0 ? b : s == 2'd1 ? ~b : s == 2'd2 ? 16'h0000 : 16'hFFFF;
    sum = {1'b0, aop} + {1'b0, bs} + {16'd0, cin};
    e.d = sum[15:0];
    e.c = sum[16];
    e.v = aop[15] ^ bs[15] ^ sum[15] ^ sum[16];
    e.z = sum[15:0] == 16'd0;
    e.n = sum[15];
    return e;
  endfunction

  task automatic start_op(input logic [15:0] a, b, input logic [1:0] s, input logic cin, accsel, clr);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL start_timeout: in_ready=%b required 1", in_ready);
    end
    A = a; B = b; S = s; C_in = cin; ACC_SEL = accsel; ACC_CLR = clr; in_valid = 1;
    q.push_back(model(a, b, s, cin, accsel));
    @(posedge clk); #1;
    in_valid = 0; ACC_CLR = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic collect(input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    last_d = e.d;
    n_checks++; if (D !== e.d) begin n_fail++; $display("FAIL %s D: got %h required %h", name, D, e.d); end
    n_checks++; if (C_out !== e.c) begin n_fail++; $display("FAIL %s C_out: got %b required %b", name, C_out, e.c); end
    n_checks++; if (V !== e.v) begin n_fail++; $display("FAIL %s V: got %b required %b", name, V, e.v); end
    n_checks++; if (Z !== e.z) begin n_fail++; $display("FAIL %s Z: got %b required %b", name, Z, e.z); end
    n_checks++; if (N !== e.n) begin n_fail++; $display("FAIL %s N: got %b required %b", name, N, e.n); end
  endtask

  task automatic accept(input string name);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    model_acc = last_d;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic run_op(input logic [15:0] a, b, input logic [1:0] s, input logic cin, accsel, input string name);
    int lat;
    start_op(a, b, s, cin, accsel, 1'b0);
    wait_done(lat);
    collect(name);
    accept(name);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b required 0", in_ready); end
    rst_n = 1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++;
    if ({out_valid, D, C_out, V, Z, N} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b D=%h C=%b V=%b Z=%b N=%b required all 0", out_valid, D, C_out, V, Z, N);
    end
  endtask

  task automatic test_accumulator();
    run_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, "acc1");
    run_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, "acc2");
    run_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, "acc3");
    ACC_CLR = 1; @(posedge clk); #1; ACC_CLR = 0;
    model_acc = 0;
    run_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, "acc_clr");
    begin
      int lat;
      start_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, 1'b1);
      wait_done(lat);
      collect("acc_clr_with_valid");
      accept("acc_clr_with_valid");
    end
    run_op(16'h5555, 16'h0, 2'd2, 1'b1, 1'b1, "acc_after_clr_valid");
  endtask

  task automatic test_add();
    int lat;
    start_op(16'h1234, 16'h0FCC, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d required 4", lat); end
    collect("add");
    accept("add");
  endtask

  task automatic test_flags();
    run_op(16'h8000, 16'h0001, 2'd1, 1'b1, 1'b0, "sub_overflow");
    run_op(16'h0000, 16'h1357, 2'd3, 1'b0, 1'b0, "ones");
    run_op(16'hFFFF, 16'h2468, 2'd2, 1'b1, 1'b0, "zero_wrap");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      run_op(16'($urandom), 16'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), "random");
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    start_op(16'h1234, 16'h0FCC, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1; A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({D, C_out, V, Z, N} !== {e.d, e.c, e.v, e.z, e.n} || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold: D=%h flags=%b%b%b%b in_ready=%b out_valid=%b required D=%h flags=%b%b%b%b 0/1",
                 D, C_out, V, Z, N, in_ready, out_valid, e.d, e.c, e.v, e.z, e.n);
      end
    end
    in_valid = 0;
    collect("backpressure");
    accept("backpressure");
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_ignored: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    start_op(16'h00FF, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0; #1;
    n_checks++;
    if (out_valid !== 1'b0 || D !== 16'h0000 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: out_valid=%b D=%h in_ready=%b required 0/0000/0", out_valid, D, in_ready);
    end
    q.delete();
    model_acc = 0;
    @(posedge clk); #1;
    rst_n = 1;
    run_op(16'hABCD, 16'h0000, 2'd2, 1'b1, 1'b1, "acc_after_reset");
    run_op(16'h00FF, 16'h0001, 2'd0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_accumulator();
    test_add();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_unit_seq.md
# arith_unit_seq

Parametrised, multi-cycle successor to the 4-bit combinational arithmetic unit. It keeps the same B-operand selection (B, ~B, all-zeros, all-ones) and carry-in semantics. It processes a WIDTH-bit operation SLICE bits per cycle, with the carry registered between slices. It adds a valid/ready handshake on input and output, status flags, and an internal accumulator that can replace operand A. It sits between the register file/sequencer and any consumer of arithmetic results.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of SLICE
- SLICE, 4, bits processed per cycle; NS = WIDTH/SLICE slice cycles per operation
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request (state IDLE)
- A  in  WIDTH  operand A (ignored when ACC_SEL=1)
- B  in  WIDTH  operand B
- S  in  2  B select: 00 B, 01 ~B, 10 all-zeros, 11 all-ones
- C_in  in  1  carry into bit 0
- ACC_SEL  in  1  1: use accumulator in place of A
- ACC_CLR  in  1  clear accumulator; sampled only in IDLE when no transfer occurs
- out_valid  out  1  result and flags valid (state DONE)
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  result = Aop + Bsel + C_in, modulo 2^WIDTH
- C_out  out  1  carry out of the MSB
- V  out  1  signed overflow = carry into MSB XOR C_out
- Z  out  1  D == 0
- N  out  1  D[WIDTH-1]

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid, on the edge: capture Aop (A, or the accumulator if ACC_SEL), Bsel, and C_in into the carry register; clear the slice index; go to RUN.
  - Otherwise, if ACC_CLR, clear the accumulator on that edge.
- RUN:
  - Each cycle, slice k (bits k*SLICE .. k*SLICE+SLICE-1) = Aop slice + Bsel slice + carry.
  - The sum is written into D's slice and the carry register updates.
  - The slice index increments.
  - After slice NS-1: latch C_out, compute V from the carry into the MSB, go to DONE.
- DONE:
  - out_valid=1.
  - D, C_out, V, Z, N are held stable until out_ready=1.
  - On the accepting edge: accumulator <= D; go to IDLE.
- The accumulator updates only on result acceptance. ACC_SEL in the next operation sees the last accepted D.
- D and the flags keep their last value in IDLE and RUN; they are defined only while out_valid=1.
- in_valid, out_ready, and input data are ignored outside their respective states.
- No operation is aborted by deasserting in_valid after capture.

## Timing
- Reset (rst_n low, asynchronous):
  - State becomes IDLE.
  - D=0, C_out=0, V=0, Z=0 (Z register reset value), N=0.
  - out_valid=0, accumulator=0, carry=0, slice index=0.
  - in_ready reads 1 when rst_n is high and the state is IDLE; no transfer happens while rst_n is low.
- Reset mid-RUN or mid-DONE discards the operation; there is no partial result and no accumulator update.
- Accept at edge t ⇒ RUN during cycles t..t+NS-1 ⇒ out_valid=1 after edge t+NS.
- Result accepted at edge u ⇒ in_ready=1 after edge u ⇒ next accept at edge u+1 at the earliest.
- Maximum throughput is one operation per NS+2 cycles.
- Back-pressure: out_ready low holds DONE indefinitely with outputs frozen; in_ready stays 0.
- NS=1 (SLICE=WIDTH) is legal: RUN lasts exactly one cycle.
- Carry wrap-around: the carry out of slice NS-1 goes to C_out only, never back into slice 0.
- ACC_CLR together with in_valid in IDLE: the transfer wins and ACC_CLR is ignored.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
- S=00, A=0x1234, B=0x0FCC, C_in=0 -> D=0x2200, C_out=0, V=0, Z=0, N=0; out_valid rises exactly 4 edges after the accept edge.
- S=01, C_in=1, A=0x8000, B=0x0001 -> D=0x7FFF, C_out=1, V=1, N=0, Z=0.
- S=11, C_in=0, A=0x0000 -> D=0xFFFF, C_out=0, V=0, N=1; then S=10, C_in=1, A=0xFFFF -> D=0x0000, C_out=1, Z=1, V=0.
- From reset, three ops with ACC_SEL=1, S=10, C_in=1 -> D=0x0001, 0x0002, 0x0003. Then ACC_CLR=1 in IDLE, then the same op -> D=0x0001.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> D and flags unchanged, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 the next cycle.
- Assert rst_n low after 2 RUN cycles of A=0x00FF, B=0x0001 -> out_valid=0, D=0, accumulator=0 immediately. After release, S=00, A=0x00FF, B=0x0001, C_in=0 -> D=0x0100, C_out=0.
